// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: shift directions, FSM states and
// the bit-counter width helper.
package piso_pkg;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

  // Counter spans 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Shift engine: loads a word, presents one registered bit per cycle in the
// word's own direction, and flags the first and last bit of each frame.
module piso_shift_core
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_lr,
  input  logic             i_shift,
  input  logic             i_clear,
  output logic             o_bit,
  output logic             o_first,
  output logic             o_last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

  logic [WIDTH-1:0] r_sr;
  logic             r_lr;
  logic [CW-1:0]    r_cnt;
  logic             r_bit;
  logic             r_first;
  logic             r_last;

  // r_sr holds the bits not yet presented; the presented bit lives in r_bit.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_lr <= i_lr;
      r_sr <= (i_lr == SHIFT_RIGHT) ? (i_data >> 1) : (i_data << 1);
    end else if (i_shift) begin
      r_sr <= (r_lr == SHIFT_RIGHT) ? (r_sr >> 1) : (r_sr << 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_bit   <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_bit   <= (i_lr == SHIFT_RIGHT) ? i_data[0] : i_data[WIDTH-1];
      r_first <= 1'b1;
      r_last  <= 1'b0;
    end else if (i_shift) begin
      r_cnt   <= r_cnt + CW'(1);
      r_bit   <= (r_lr == SHIFT_RIGHT) ? r_sr[0] : r_sr[WIDTH-1];
      r_first <= 1'b0;
      r_last  <= (r_cnt == CNT_PENULT);
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_bit   <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_bit   = r_bit;
  assign o_first = r_first;
  assign o_last  = r_last;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready input, a one-word hold
// buffer for gapless back-to-back frames, and framed serial output.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_first,
  output logic             so_last
);

  piso_state_e      r_state;
  piso_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_hold_data;
  logic             r_hold_lr;
  logic             r_hold_full;

  logic             w_xfer;
  logic             w_last;
  logic             w_bit;
  logic             w_first;
  logic             w_load;
  logic             w_load_hold;
  logic             w_shift;
  logic             w_clear;
  logic             w_hold_wr;
  logic             w_hold_clr;
  logic [WIDTH-1:0] w_load_data;
  logic             w_load_lr;

  assign in_ready = !r_hold_full && !rst;
  assign w_xfer   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_xfer) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last && !r_hold_full && !w_xfer) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // On the last-bit edge a waiting hold word takes priority over a new input.
  always_comb begin
    w_load      = 1'b0;
    w_load_hold = 1'b0;
    w_shift     = 1'b0;
    w_clear     = 1'b0;
    w_hold_wr   = 1'b0;
    w_hold_clr  = 1'b0;
    case (r_state)
      ST_IDLE: w_load = w_xfer;
      ST_SHIFT: begin
        if (!w_last) begin
          w_shift   = 1'b1;
          w_hold_wr = w_xfer;
        end else if (r_hold_full) begin
          w_load      = 1'b1;
          w_load_hold = 1'b1;
          w_hold_clr  = 1'b1;
          w_hold_wr   = w_xfer;
        end else if (w_xfer) begin
          w_load = 1'b1;
        end else begin
          w_clear = 1'b1;
        end
      end
      default: w_clear = 1'b1;
    endcase
  end

  assign w_load_data = w_load_hold ? r_hold_data : in_data;
  assign w_load_lr   = w_load_hold ? r_hold_lr   : in_lr;

  always_ff @(posedge clk) begin
    if (w_hold_wr) begin
      r_hold_data <= in_data;
      r_hold_lr   <= in_lr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_hold_full <= 1'b0;
    else if (w_hold_wr)  r_hold_full <= 1'b1;
    else if (w_hold_clr) r_hold_full <= 1'b0;
  end

  piso_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_lr    (w_load_lr),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .o_bit   (w_bit),
    .o_first (w_first),
    .o_last  (w_last)
  );

  assign so       = w_bit;
  assign so_valid = (r_state == ST_SHIFT);
  assign so_first = w_first;
  assign so_last  = w_last;

  // A full hold buffer must never see a simultaneous new transfer.
  a_no_xfer_when_full: assert property (
    @(posedge clk) disable iff (rst) !(in_valid && in_ready && r_hold_full)
  );

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: WIDTH=8 and WIDTH=2 instances share
// clock and reset; outputs are sampled on the falling edge.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic [7:0] d8;
  logic       lr8, v8, rdy8, so8, sv8, sf8, sl8;
  logic [1:0] d2;
  logic       lr2, v2, rdy2, so2, sv2, sf2, sl2;

  int n_vec  = 0;
  int n_miss = 0;

  piso_serializer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_data(d8), .in_lr(lr8), .in_valid(v8),
    .in_ready(rdy8), .so(so8), .so_valid(sv8), .so_first(sf8), .so_last(sl8)
  );

  piso_serializer #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(d2), .in_lr(lr2), .in_valid(v2),
    .in_ready(rdy2), .so(so2), .so_valid(sv2), .so_first(sf2), .so_last(sl2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends one word from idle; exp_bits lists the serial bits first-to-last, MSB of arg first.
  // Packed flags compared per cycle: {so, so_valid, so_first, so_last, in_ready}.
  task automatic run_word(input logic [7:0] d, input logic lr, input logic [7:0] exp_bits,
                          input string tag);
    logic [4:0] exp;
    @(negedge clk);
    check({tag, "_rdy_pre"}, 32'(rdy8), 32'd1);
    d8 = d; lr8 = lr; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {exp_bits[7-i], 1'b1, (i == 0), (i == 7), 1'b1};
      check($sformatf("%s_bit%0d", tag, i), 32'({so8, sv8, sf8, sl8, rdy8}), 32'(exp));
      @(negedge clk);
    end
    check({tag, "_after"}, 32'({so8, sv8, sf8, sl8}), 32'd0);
  endtask

  initial begin
    logic [15:0] exp16;
    logic [4:0]  exp;
    logic [31:0] stream;
    int          nbits;
    int          nvld;

    rst = 1'b1;
    d8 = '0; lr8 = 1'b0; v8 = 1'b0;
    d2 = '0; lr2 = 1'b0; v2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out8", 32'({so8, sv8, sf8, sl8, rdy8}), 32'd0);
    check("rst_out2", 32'({so2, sv2, sf2, sl2, rdy2}), 32'd0);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", 32'({rdy8, rdy2}), 32'b11);

    run_word(8'hA5, 1'b0, 8'hA5, "a5_msb");
    run_word(8'hA5, 1'b1, 8'hA5, "a5_lsb");
    run_word(8'h01, 1'b1, 8'h80, "01_lsb");

    // Back-to-back F0 (MSB first) then 0F (LSB first).
    exp16 = 16'b1111000011110000;
    @(negedge clk);
    d8 = 8'hF0; lr8 = 1'b0; v8 = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      exp = {exp16[16-i], 1'b1, (i == 1 || i == 9), (i == 8 || i == 16), !(i >= 2 && i <= 8)};
      check($sformatf("b2b_c%0d", i), 32'({so8, sv8, sf8, sl8, rdy8}), 32'(exp));
      if (i == 1) begin
        d8 = 8'h0F; lr8 = 1'b1;
      end else if (i <= 7) begin
        d8 = 8'($urandom);
      end else if (i == 8) begin
        v8 = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_end", 32'({so8, sv8}), 32'd0);

    // Reset during the 4th bit while the hold buffer is full.
    @(negedge clk);
    d8 = 8'hC3; lr8 = 1'b0; v8 = 1'b1;
    @(negedge clk);
    d8 = 8'h3C; lr8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    check("mid_hold_full", 32'(rdy8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("mid_bit4", 32'({so8, sv8}), 32'b01);
    rst = 1'b1;
    #1;
    check("mid_rst_out", 32'({so8, sv8, sf8, sl8, rdy8}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rdy_rel", 32'(rdy8), 32'd1);
    nvld = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sv8) nvld++;
    end
    check("mid_no_frame", 32'(nvld), 32'd0);

    // in_valid toggling while in_ready=0 must add no frames.
    stream = '0;
    nbits  = 0;
    @(negedge clk);
    d8 = 8'h96; lr8 = 1'b0; v8 = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 30; i++) begin
      if (sv8) begin
        stream = {stream[30:0], so8};
        nbits++;
      end
      if (i == 1) begin
        d8 = 8'h6C; lr8 = 1'b1;
      end else if (i <= 7) begin
        v8 = (i % 2 == 1);
        d8 = 8'($urandom);
        lr8 = 1'($urandom);
      end else if (i == 8) begin
        v8 = 1'b0;
      end
      @(negedge clk);
    end
    check("tog_nbits", 32'(nbits), 32'd16);
    check("tog_stream", stream, 32'h0000_9636);

    // WIDTH=2: 10 MSB-first then 10 LSB-first.
    @(negedge clk);
    d2 = 2'b10; lr2 = 1'b0; v2 = 1'b1;
    @(negedge clk);
    check("w2_c1", 32'({so2, sv2, sf2, sl2}), 32'b1110);
    d2 = 2'b10; lr2 = 1'b1;
    @(negedge clk);
    check("w2_c2", 32'({so2, sv2, sf2, sl2, rdy2}), 32'b01010);
    v2 = 1'b0;
    @(negedge clk);
    check("w2_c3", 32'({so2, sv2, sf2, sl2}), 32'b0110);
    @(negedge clk);
    check("w2_c4", 32'({so2, sv2, sf2, sl2}), 32'b1101);
    @(negedge clk);
    check("w2_c5", 32'({so2, sv2, sf2, sl2, rdy2}), 32'b00001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
